// File: rtl/jesd204_rx_sh_pkg.sv
// Shared definitions for the JESD204C 64B66B receive sync-header lock logic:
// lane FSM state encoding and the header helper functions.
package jesd204_rx_sh_pkg;

  typedef enum logic [1:0] {
    SH_HUNT = 2'd0,
    SH_SLIP = 2'd1,
    SH_WAIT = 2'd2,
    SH_LOCK = 2'd3
  } sh_state_e;

  localparam int SH_ERR_CNT_W = 16;

  // A 64B66B sync header is valid only when its two bits differ.
  function automatic logic sh_hdr_valid(input logic [1:0] hdr);
    return hdr[1] ^ hdr[0];
  endfunction

  // The GT delivers the header LSB-first; the link layer expects it MSB-first.
  function automatic logic [1:0] sh_swap(input logic [1:0] raw);
    return {raw[0], raw[1]};
  endfunction

endpackage

// File: rtl/jesd204_rx_sh_lock_fsm.sv
// One lane's sync-header lock FSM (HUNT/SLIP/WAIT/LOCK), its counters and the
// gearbox slip pulse. Optional macro JESD204_RX_SH_ERR_CNT_EN adds a
// saturating count of invalid headers seen while locked.
module jesd204_rx_sh_lock_fsm
  import jesd204_rx_sh_pkg::*;
#(
  parameter int SH_LOCK_CNT = 64,
  parameter int SH_WIN      = 64,
  parameter int SH_ERR_MAX  = 16,
  parameter int SLIP_WAIT   = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       lane_en,
  input  logic       hdr_qual,
  input  logic [1:0] hdr,
  output logic       slip,
  output logic       block_sync
`ifdef JESD204_RX_SH_ERR_CNT_EN
  , output logic [SH_ERR_CNT_W-1:0] sh_err_cnt
`endif
);

  localparam int GW = $clog2(SH_LOCK_CNT);
  localparam int WW = $clog2(SH_WIN);

  sh_state_e     state_q, state_d;
  logic [GW-1:0] good_q, good_d;
  logic [7:0]    wait_q, wait_d;
  logic [WW-1:0] win_q, win_d;
  logic [WW:0]   err_q, err_d;
  logic [WW:0]   err_sum;
  logic          slip_q, slip_d;
  logic          sync_q, sync_d;
  logic          hdr_ok;

  // Next-state and counter update; a disabled lane is forced back to a clean HUNT.
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    wait_d  = wait_q;
    win_d   = win_q;
    err_d   = err_q;
    hdr_ok  = sh_hdr_valid(hdr);
    err_sum = err_q + {{WW{1'b0}}, ~hdr_ok};
    if (!lane_en) begin
      state_d = SH_HUNT;
      good_d  = '0;
      wait_d  = '0;
      win_d   = '0;
      err_d   = '0;
    end else begin
      case (state_q)
        SH_HUNT: begin
          if (hdr_qual) begin
            if (!hdr_ok) begin
              good_d  = '0;
              state_d = SH_SLIP;
            end else if (good_q == GW'(SH_LOCK_CNT - 1)) begin
              good_d  = '0;
              state_d = SH_LOCK;
            end else begin
              good_d = good_q + 1'b1;
            end
          end
        end
        SH_SLIP: begin
          wait_d  = '0;
          state_d = SH_WAIT;
        end
        SH_WAIT: begin
          // Settling time counts raw cycles; headers are meaningless while the gearbox moves.
          if (wait_q == 8'(SLIP_WAIT - 1)) begin
            wait_d  = '0;
            good_d  = '0;
            state_d = SH_HUNT;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end
        SH_LOCK: begin
          if (hdr_qual) begin
            // Error threshold is checked before window end so unlock wins a tie.
            if (err_sum == (WW + 1)'(SH_ERR_MAX)) begin
              win_d   = '0;
              err_d   = '0;
              state_d = SH_SLIP;
            end else if (win_q == WW'(SH_WIN - 1)) begin
              win_d = '0;
              err_d = '0;
            end else begin
              win_d = win_q + 1'b1;
              err_d = err_sum;
            end
          end
        end
        default: state_d = SH_HUNT;
      endcase
    end
    slip_d = (state_d == SH_SLIP);
    sync_d = (state_d == SH_LOCK);
  end

  // FSM state, counters and registered slip/lock outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SH_HUNT;
      good_q  <= '0;
      wait_q  <= '0;
      win_q   <= '0;
      err_q   <= '0;
      slip_q  <= 1'b0;
      sync_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
      wait_q  <= wait_d;
      win_q   <= win_d;
      err_q   <= err_d;
      slip_q  <= slip_d;
      sync_q  <= sync_d;
    end
  end

  assign slip       = slip_q;
  assign block_sync = sync_q;

`ifdef JESD204_RX_SH_ERR_CNT_EN
  logic [SH_ERR_CNT_W-1:0] ecnt_q, ecnt_d;

  // Lifetime invalid-header count while locked, holding at all-ones.
  always_comb begin
    ecnt_d = ecnt_q;
    if (!lane_en) begin
      ecnt_d = '0;
    end else if ((state_q == SH_LOCK) && hdr_qual && !hdr_ok && (ecnt_q != '1)) begin
      ecnt_d = ecnt_q + 1'b1;
    end
  end

  // Error count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ecnt_q <= '0;
    else        ecnt_q <= ecnt_d;
  end

  assign sh_err_cnt = ecnt_q;
`endif

endmodule

// File: rtl/jesd204_versal_gt_adapter_rx_mlane.sv
// Multi-lane Versal GT RX to JESD204C 64B66B adapter: per-lane bit reversal,
// header swap and qualifier register, one lock FSM per lane, and the
// aggregate block-sync flag. Optional macro JESD204_RX_SH_ERR_CNT_EN exposes
// per-lane invalid-header counters on rx_sh_err_cnt.
module jesd204_versal_gt_adapter_rx_mlane
  import jesd204_rx_sh_pkg::*;
#(
  parameter int NUM_LANES   = 4,
  parameter int SH_LOCK_CNT = 64,
  parameter int SH_WIN      = 64,
  parameter int SH_ERR_MAX  = 16,
  parameter int SLIP_WAIT   = 32
) (
  input  logic                     usr_clk,
  input  logic                     resetn,
  input  logic [NUM_LANES-1:0]     lane_enable,
  input  logic [NUM_LANES*128-1:0] rxdata,
  input  logic [NUM_LANES*6-1:0]   rxheader,
  input  logic [NUM_LANES*2-1:0]   rxheadervalid,
  output logic [NUM_LANES-1:0]     rxgearboxslip,
  output logic [NUM_LANES*64-1:0]  rx_data,
  output logic [NUM_LANES*2-1:0]   rx_header,
  output logic [NUM_LANES-1:0]     rx_valid,
  output logic [NUM_LANES-1:0]     rx_block_sync,
  output logic                     rx_block_sync_all
`ifdef JESD204_RX_SH_ERR_CNT_EN
  , output logic [NUM_LANES*SH_ERR_CNT_W-1:0] rx_sh_err_cnt
`endif
);

  logic [NUM_LANES*64-1:0] rx_data_q, rx_data_d;
  logic [NUM_LANES*2-1:0]  rx_header_q, rx_header_d;
  logic [NUM_LANES-1:0]    rx_valid_q, rx_valid_d;
  logic                    sync_all_q, sync_all_d;

  // Datapath reformatting and the enabled-lane AND of block sync.
  always_comb begin
    rx_data_d   = '0;
    rx_header_d = '0;
    rx_valid_d  = '0;
    for (int n = 0; n < NUM_LANES; n++) begin
      for (int i = 0; i < 64; i++) begin
        rx_data_d[n*64+63-i] = rxdata[n*128+i];
      end
      rx_header_d[n*2 +: 2] = sh_swap(rxheader[n*6 +: 2]);
      rx_valid_d[n]         = rxheadervalid[n*2];
    end
    sync_all_d = (|lane_enable) & (&(rx_block_sync | ~lane_enable));
  end

  // Output registers; one cycle of latency independent of lock state.
  always_ff @(posedge usr_clk or negedge resetn) begin
    if (!resetn) begin
      rx_data_q   <= '0;
      rx_header_q <= '0;
      rx_valid_q  <= '0;
      sync_all_q  <= 1'b0;
    end else begin
      rx_data_q   <= rx_data_d;
      rx_header_q <= rx_header_d;
      rx_valid_q  <= rx_valid_d;
      sync_all_q  <= sync_all_d;
    end
  end

  assign rx_data           = rx_data_q;
  assign rx_header         = rx_header_q;
  assign rx_valid          = rx_valid_q;
  assign rx_block_sync_all = sync_all_q;

  for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
    // Upper data half, spare header bits and odd qualifier bits carry nothing in 64B66B mode.
    logic lane_unused;
    assign lane_unused = ^{rxdata[n*128+64 +: 64], rxheader[n*6+2 +: 4], rxheadervalid[n*2+1]};

    jesd204_rx_sh_lock_fsm #(
      .SH_LOCK_CNT (SH_LOCK_CNT),
      .SH_WIN      (SH_WIN),
      .SH_ERR_MAX  (SH_ERR_MAX),
      .SLIP_WAIT   (SLIP_WAIT)
    ) u_fsm (
      .clk        (usr_clk),
      .rst_n      (resetn),
      .lane_en    (lane_enable[n]),
      .hdr_qual   (rxheadervalid[n*2]),
      .hdr        (sh_swap(rxheader[n*6 +: 2])),
      .slip       (rxgearboxslip[n]),
      .block_sync (rx_block_sync[n])
`ifdef JESD204_RX_SH_ERR_CNT_EN
      , .sh_err_cnt (rx_sh_err_cnt[n*SH_ERR_CNT_W +: SH_ERR_CNT_W])
`endif
    );
  end

endmodule

// File: tb/tb_jesd204_versal_gt_adapter_rx_mlane.sv
// Self-checking bench for jesd204_versal_gt_adapter_rx_mlane (4 lanes, default
// thresholds). Compares every output each cycle against a lane model built
// from the lock/unlock rules; JESD204_RX_SH_ERR_CNT_EN also checks rx_sh_err_cnt.
module tb_jesd204_versal_gt_adapter_rx_mlane;

  localparam int NL       = 4;
  localparam int LOCK_CNT = 64;
  localparam int WIN      = 64;
  localparam int ERR_MAX  = 16;
  localparam int SWAIT    = 32;

  logic                usr_clk = 1'b0;
  logic                resetn;
  logic [NL-1:0]       lane_enable;
  logic [NL*128-1:0]   rxdata;
  logic [NL*6-1:0]     rxheader;
  logic [NL*2-1:0]     rxheadervalid;
  logic [NL-1:0]       rxgearboxslip;
  logic [NL*64-1:0]    rx_data;
  logic [NL*2-1:0]     rx_header;
  logic [NL-1:0]       rx_valid;
  logic [NL-1:0]       rx_block_sync;
  logic                rx_block_sync_all;
`ifdef JESD204_RX_SH_ERR_CNT_EN
  logic [NL*16-1:0]    rx_sh_err_cnt;
`endif

  jesd204_versal_gt_adapter_rx_mlane #(
    .NUM_LANES(NL), .SH_LOCK_CNT(LOCK_CNT), .SH_WIN(WIN), .SH_ERR_MAX(ERR_MAX), .SLIP_WAIT(SWAIT)
  ) dut (
    .usr_clk           (usr_clk),
    .resetn            (resetn),
    .lane_enable       (lane_enable),
    .rxdata            (rxdata),
    .rxheader          (rxheader),
    .rxheadervalid     (rxheadervalid),
    .rxgearboxslip     (rxgearboxslip),
    .rx_data           (rx_data),
    .rx_header         (rx_header),
    .rx_valid          (rx_valid),
    .rx_block_sync     (rx_block_sync),
    .rx_block_sync_all (rx_block_sync_all)
`ifdef JESD204_RX_SH_ERR_CNT_EN
    , .rx_sh_err_cnt   (rx_sh_err_cnt)
`endif
  );

  always #5 usr_clk = ~usr_clk;

  int ncmp  = 0;
  int nfail = 0;

  // Stimulus intent per lane (header is the post-swap value the link layer should see).
  logic [1:0]    cur_hdr [NL];
  bit            cur_q   [NL];
  logic [NL-1:0] cur_en;

  // Reference model: run length toward lock, remaining settle cycles, window tallies.
  bit m_lock [NL];
  bit m_slip [NL];
  int m_run  [NL];
  int m_wait [NL];
  int m_win  [NL];
  int m_err  [NL];
  int m_ecnt [NL];

  logic [NL*64-1:0] e_data;
  logic [NL*2-1:0]  e_hdr;
  logic [NL-1:0]    e_valid, e_slip, e_sync;
  logic             e_all;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".rx_data"},   256'(rx_data),           256'(e_data));
    chk({tag, ".rx_header"}, 256'(rx_header),         256'(e_hdr));
    chk({tag, ".rx_valid"},  256'(rx_valid),          256'(e_valid));
    chk({tag, ".slip"},      256'(rxgearboxslip),     256'(e_slip));
    chk({tag, ".sync"},      256'(rx_block_sync),     256'(e_sync));
    chk({tag, ".sync_all"},  256'(rx_block_sync_all), 256'(e_all));
`ifdef JESD204_RX_SH_ERR_CNT_EN
    for (int n = 0; n < NL; n++)
      chk({tag, ".err_cnt"}, 256'(rx_sh_err_cnt[n*16 +: 16]), 256'(m_ecnt[n]));
`endif
  endtask

  task automatic model_reset();
    for (int n = 0; n < NL; n++) begin
      m_lock[n] = 0; m_slip[n] = 0; m_run[n] = 0; m_wait[n] = 0;
      m_win[n] = 0; m_err[n] = 0; m_ecnt[n] = 0;
    end
    e_data = '0; e_hdr = '0; e_valid = '0; e_slip = '0; e_sync = '0; e_all = 1'b0;
  endtask

  task automatic drive();
    for (int n = 0; n < NL; n++) begin
      for (int k = 0; k < 4; k++) rxdata[n*128 + k*32 +: 32] = $urandom;
      rxheader[n*6 +: 6]      = {4'($urandom), cur_hdr[n][0], cur_hdr[n][1]};
      rxheadervalid[n*2 +: 2] = {1'($urandom), cur_q[n]};
    end
    lane_enable = cur_en;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    logic [NL-1:0] sync_old;
    bit bad;
    sync_old = e_sync;
    for (int n = 0; n < NL; n++) begin
      for (int i = 0; i < 64; i++) e_data[n*64 + 63 - i] = rxdata[n*128 + i];
      e_hdr[n*2 +: 2] = cur_hdr[n];
      e_valid[n]      = cur_q[n];
      bad = (cur_hdr[n] == 2'b00) || (cur_hdr[n] == 2'b11);
      if (!cur_en[n]) begin
        m_lock[n] = 0; m_slip[n] = 0; m_run[n] = 0; m_wait[n] = 0;
        m_win[n] = 0; m_err[n] = 0; m_ecnt[n] = 0;
      end else if (m_slip[n]) begin
        m_slip[n] = 0;
        m_wait[n] = SWAIT;
      end else if (m_wait[n] > 0) begin
        m_wait[n]--;
        if (m_wait[n] == 0) m_run[n] = 0;
      end else if (m_lock[n]) begin
        if (cur_q[n]) begin
          if (bad && m_ecnt[n] < 65535) m_ecnt[n]++;
          m_win[n]++;
          if (bad) m_err[n]++;
          if (m_err[n] == ERR_MAX) begin
            m_lock[n] = 0; m_slip[n] = 1; m_win[n] = 0; m_err[n] = 0;
          end else if (m_win[n] == WIN) begin
            m_win[n] = 0; m_err[n] = 0;
          end
        end
      end else if (cur_q[n]) begin
        if (bad) begin
          m_run[n] = 0; m_slip[n] = 1;
        end else begin
          m_run[n]++;
          if (m_run[n] == LOCK_CNT) begin
            m_lock[n] = 1; m_run[n] = 0;
          end
        end
      end
      e_slip[n] = m_slip[n];
      e_sync[n] = m_lock[n];
    end
    e_all = (|cur_en) && ((sync_old | ~cur_en) == '1);
  endtask

  task automatic cycle(input string tag);
    @(negedge usr_clk);
    drive();
    model_step();
    @(posedge usr_clk);
    #1;
    check_all(tag);
  endtask

  task automatic set_all(input logic [1:0] h, input bit q);
    for (int n = 0; n < NL; n++) begin
      cur_hdr[n] = h;
      cur_q[n]   = q;
    end
  endtask

  // Assert reset between edges, check outputs, release just after a rising edge.
  task automatic do_reset();
    resetn = 1'b0;
    model_reset();
    #1;
    check_all("reset");
    repeat (2) @(posedge usr_clk);
    #1;
    resetn = 1'b1;
  endtask

  initial begin
    cur_en = '1;
    set_all(2'b01, 1'b1);
    drive();
    resetn = 1'b1;
    #2;
    do_reset();

    // Constant valid header on all lanes: lock after 64 headers, aggregate one cycle later.
    for (int k = 0; k < 70; k++) cycle("lock_all");
    chk("lock_all.final_sync", 256'(rx_block_sync), 256'(4'hF));

    // Lane 2 sees invalid headers: periodic slips, then relock on valid headers.
    cur_hdr[2] = 2'b11;
    for (int k = 0; k < 200; k++) cycle("lane2_bad");
    cur_hdr[2] = 2'b10;
    for (int k = 0; k < 120; k++) cycle("lane2_relock");
    chk("lane2_relock.sync", 256'(rx_block_sync[2]), 256'(1'b1));

    // 15 errors per window keeps lock; 16 errors in a window drops it.
    for (int k = 0; k < 256; k++) begin
      cur_hdr[0] = ((k % 64) < 15) ? 2'b00 : 2'b01;
      cycle("err15");
    end
    chk("err15.still_locked", 256'(rx_block_sync[0]), 256'(1'b1));
    for (int k = 0; k < 40; k++) begin
      cur_hdr[0] = (k < 16) ? 2'b11 : 2'b01;
      cycle("err16");
    end
    chk("err16.unlocked", 256'(rx_block_sync[0]), 256'(1'b0));
    for (int k = 0; k < 100; k++) cycle("err16_relock");

    // Qualifier toggling from HUNT; invalid headers under a low qualifier are ignored.
    do_reset();
    set_all(2'b01, 1'b1);
    for (int k = 0; k < 140; k++) begin
      for (int n = 0; n < NL; n++) cur_q[n] = (k % 2) == 0;
      cycle("qual_toggle");
    end
    for (int k = 0; k < 200; k++) begin
      for (int n = 0; n < NL; n++) begin
        cur_q[n]   = (k % 2) == 1;
        cur_hdr[n] = cur_q[n] ? 2'b10 : 2'b11;
      end
      cycle("qual_ignore");
    end
    chk("qual_ignore.sync", 256'(rx_block_sync), 256'(4'hF));

    // Lane enable handling.
    set_all(2'b01, 1'b1);
    cur_en[1] = 1'b0;
    for (int k = 0; k < 4; k++) cycle("disable1");
    chk("disable1.sync_all", 256'(rx_block_sync_all), 256'(1'b1));
    cur_en = '0;
    for (int k = 0; k < 4; k++) cycle("disable_all");
    chk("disable_all.sync_all", 256'(rx_block_sync_all), 256'(1'b0));
    cur_en = '1;
    for (int k = 0; k < 70; k++) cycle("reenable");

    // Randomized headers, qualifiers and occasional lane enable flips.
    for (int k = 0; k < 3000; k++) begin
      for (int n = 0; n < NL; n++) begin
        cur_q[n] = ($urandom_range(0, 7) != 0);
        if ($urandom_range(0, 20 + 40 * n) == 0) cur_hdr[n] = $urandom_range(0, 1) ? 2'b00 : 2'b11;
        else                                     cur_hdr[n] = $urandom_range(0, 1) ? 2'b01 : 2'b10;
        if ($urandom_range(0, 499) == 0) cur_en[n] = ~cur_en[n];
      end
      cycle("random");
    end

    // Asynchronous reset in the middle of a lane-2 settle period.
    cur_en = '1;
    set_all(2'b01, 1'b1);
    cur_hdr[2] = 2'b11;
    for (int k = 0; k < 100; k++) begin
      cycle("pre_async");
      if (m_wait[2] == 16) break;
    end
    chk("pre_async.in_wait", 256'(m_wait[2]), 256'(16));
    #2;
    do_reset();
    set_all(2'b01, 1'b1);
    for (int k = 0; k < 70; k++) cycle("post_async");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
